// File: rtl/mulu_seq.sv
// mulu_seq: radix-2 shift-add multiplier for X_WIDTH x Y_WIDTH operands, one partial product per cycle.
// The product is returned as a registered magnitude p plus sign s, announced by a one-cycle valid strobe.
module mulu_seq #(
   parameter int X_WIDTH   = 4,
   parameter int Y_WIDTH   = 4,
   parameter int SIGNED_EN = 1,
   parameter int P_WIDTH   = X_WIDTH + Y_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sgn,
   input  logic [X_WIDTH-1:0] x,
   input  logic [Y_WIDTH-1:0] y,
   output logic [P_WIDTH-1:0] p,
   output logic               s,
   output logic               rdy,
   output logic               valid
);
   localparam int CNT_W = $clog2(Y_WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic               signed_mode;
   logic [X_WIDTH:0]   x_ext;
   logic [X_WIDTH:0]   x_abs;
   logic [Y_WIDTH-1:0] y_abs;
   logic [P_WIDTH-1:0] mcand;
   logic [P_WIDTH-1:0] acc;
   logic [P_WIDTH-1:0] acc_sum;
   logic [Y_WIDTH-1:0] mplier;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic               last;
   logic               accept;

   assign signed_mode = (SIGNED_EN != 0) && sgn;

   // x is sign-extended by one bit first so the most negative value negates to its true magnitude
   assign x_ext   = {signed_mode & x[X_WIDTH-1], x};
   assign x_abs   = (signed_mode && x[X_WIDTH-1]) ? -x_ext : x_ext;
   assign y_abs   = (signed_mode && y[Y_WIDTH-1]) ? -y : y;
   assign acc_sum = acc + (mplier[0] ? mcand : '0);
   assign last    = (cnt == CNT_W'(Y_WIDTH - 1));
   assign accept  = (state == IDLE) && start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept, one shift-add step per RUN cycle, result load on the final step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         p      <= '0;
         s      <= 1'b0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (accept) begin
            mcand  <= {{(P_WIDTH-X_WIDTH-1){1'b0}}, x_abs};
            mplier <= y_abs;
            neg    <= signed_mode & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
               p     <= acc_sum;
               s     <= neg & (|acc_sum);
               valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mulu_seq.sv
// tb_mulu_seq: drives a 4x4 signed instance and an 8x6 unsigned-only instance of mulu_seq
// and compares every result against a plain integer-arithmetic product model.
module tb_mulu_seq;
   logic        clk = 1'b0;

   logic        rst0, start0, sgn0;
   logic [3:0]  x0, y0;
   logic [7:0]  p0;
   logic        s0, rdy0, valid0;

   logic        rst1, start1, sgn1;
   logic [7:0]  x1;
   logic [5:0]  y1;
   logic [13:0] p1;
   logic        s1, rdy1, valid1;

   int          n_cmp = 0;
   int          n_err = 0;
   longint      last_p [2];
   longint      last_s [2];

   always #5 clk = ~clk;

   mulu_seq #(.X_WIDTH(4), .Y_WIDTH(4), .SIGNED_EN(1)) u_dut0 (
      .clk(clk), .reset(rst0), .start(start0), .sgn(sgn0), .x(x0), .y(y0),
      .p(p0), .s(s0), .rdy(rdy0), .valid(valid0)
   );

   mulu_seq #(.X_WIDTH(8), .Y_WIDTH(6), .SIGNED_EN(0)) u_dut1 (
      .clk(clk), .reset(rst1), .start(start1), .sgn(sgn1), .x(x1), .y(y1),
      .p(p1), .s(s1), .rdy(rdy1), .valid(valid1)
   );

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint get_p(input int w);
      return (w == 0) ? longint'(p0) : longint'(p1);
   endfunction

   function automatic longint get_s(input int w);
      return (w == 0) ? longint'(s0) : longint'(s1);
   endfunction

   function automatic longint get_rdy(input int w);
      return (w == 0) ? longint'(rdy0) : longint'(rdy1);
   endfunction

   function automatic longint get_valid(input int w);
      return (w == 0) ? longint'(valid0) : longint'(valid1);
   endfunction

   // Product as signed integers, then split into magnitude and sign
   function automatic void model(input bit sen, input bit sg, input int unsigned xv, input int unsigned yv,
                                 input int xw, input int yw, output longint ep, output longint es);
      longint xs, ys, prod;
      xs = longint'(xv);
      ys = longint'(yv);
      if (sen && sg && xv >= (32'd1 << (xw - 1))) xs = xs - (longint'(1) << xw);
      if (sen && sg && yv >= (32'd1 << (yw - 1))) ys = ys - (longint'(1) << yw);
      prod = xs * ys;
      es   = (prod < 0) ? 1 : 0;
      ep   = (prod < 0) ? -prod : prod;
   endfunction

   task automatic applyStimulus(input int w, input bit st, input bit sg, input int unsigned xv, input int unsigned yv);
      if (w == 0) begin
         start0 = st; sgn0 = sg; x0 = xv[3:0]; y0 = yv[3:0];
      end else begin
         start1 = st; sgn1 = sg; x1 = xv[7:0]; y1 = yv[5:0];
      end
   endtask

   task automatic set_rst(input int w, input bit v);
      if (w == 0) rst0 = v;
      else        rst1 = v;
   endtask

   // Entered and left just after a falling edge; operands are scrambled while the operation runs
   task automatic run_op(input int w, input bit sg, input int unsigned xv, input int unsigned yv,
                         input bit keep_start, input bit busy_pulse);
      int     xw, yw;
      longint ep, es;
      xw = (w == 0) ? 4 : 8;
      yw = (w == 0) ? 4 : 6;
      model(w == 0, sg, xv, yv, xw, yw, ep, es);
      applyStimulus(w, 1'b1, sg, xv, yv);
      checkOutput("rdy_before_accept", get_rdy(w), 1);
      @(negedge clk);
      checkOutput("rdy_after_accept", get_rdy(w), 0);
      checkOutput("valid_after_accept", get_valid(w), 0);
      checkOutput("p_held_at_start", get_p(w), last_p[w]);
      checkOutput("s_held_at_start", get_s(w), last_s[w]);
      for (int k = 1; k <= yw; k++) begin
         if (busy_pulse) applyStimulus(w, k == 2, 1'b0, 2, 2);
         else applyStimulus(w, keep_start ? 1'b1 : 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom, $urandom);
         @(negedge clk);
         if (k < yw) begin
            checkOutput("rdy_busy", get_rdy(w), 0);
            checkOutput("valid_busy", get_valid(w), 0);
         end else begin
            checkOutput("valid_done", get_valid(w), 1);
            checkOutput("rdy_done", get_rdy(w), 1);
            checkOutput("p_result", get_p(w), ep);
            checkOutput("s_result", get_s(w), es);
         end
      end
      if (!keep_start) applyStimulus(w, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      last_p[w] = ep;
      last_s[w] = es;
   endtask

   task automatic idle(input int w, input int n);
      applyStimulus(w, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      repeat (n) begin
         @(negedge clk);
         checkOutput("valid_idle", get_valid(w), 0);
         checkOutput("rdy_idle", get_rdy(w), 1);
         checkOutput("p_idle_hold", get_p(w), last_p[w]);
         checkOutput("s_idle_hold", get_s(w), last_s[w]);
      end
   endtask

   // Accept an operation, then assert reset just after edge A+2 and check the asynchronous abort
   task automatic reset_mid(input int w, input bit sg, input int unsigned xv, input int unsigned yv);
      applyStimulus(w, 1'b1, sg, xv, yv);
      @(negedge clk);
      applyStimulus(w, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      @(posedge clk);
      #2;
      set_rst(w, 1'b1);
      #1;
      checkOutput("p_async_reset", get_p(w), 0);
      checkOutput("s_async_reset", get_s(w), 0);
      checkOutput("rdy_async_reset", get_rdy(w), 1);
      checkOutput("valid_async_reset", get_valid(w), 0);
      @(negedge clk);
      checkOutput("valid_in_reset", get_valid(w), 0);
      checkOutput("rdy_in_reset", get_rdy(w), 1);
      set_rst(w, 1'b0);
      last_p[w] = 0;
      last_s[w] = 0;
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 0, 0);
      applyStimulus(1, 1'b0, 1'b0, 0, 0);
      last_p[0] = 0; last_p[1] = 0;
      last_s[0] = 0; last_s[1] = 0;
      #1;
      rst0 = 1'b1; rst1 = 1'b1;
      #1;
      for (int w = 0; w < 2; w++) begin
         checkOutput("reset_p", get_p(w), 0);
         checkOutput("reset_s", get_s(w), 0);
         checkOutput("reset_valid", get_valid(w), 0);
         checkOutput("reset_rdy", get_rdy(w), 1);
      end
      @(negedge clk);
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;

      run_op(0, 1'b0, 15, 15, 1'b0, 1'b0);
      idle(0, 2);
      run_op(0, 1'b1, 4'b1000, 4'b0111, 1'b0, 1'b0);
      idle(0, 1);
      run_op(0, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0);
      idle(0, 1);
      run_op(0, 1'b1, 0, 4'b1101, 1'b0, 1'b0);
      idle(0, 1);
      run_op(0, 1'b0, 3, 5, 1'b0, 1'b1);
      idle(0, 3);
      run_op(0, 1'b0, 9, 9, 1'b1, 1'b0);
      run_op(0, 1'b0, 10, 3, 1'b0, 1'b0);
      idle(0, 1);
      reset_mid(0, 1'b0, 11, 13);
      run_op(0, 1'b0, 6, 7, 1'b0, 1'b0);
      idle(0, 1);
      for (int i = 0; i < 24; i++) begin
         run_op(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom_range(0, 1)), 1'b0);
      end
      idle(0, 1);

      run_op(1, 1'b0, 255, 63, 1'b0, 1'b0);
      idle(1, 1);
      run_op(1, 1'b1, 255, 63, 1'b0, 1'b0);
      idle(1, 1);
      reset_mid(1, 1'b0, 100, 50);
      run_op(1, 1'b0, 255, 63, 1'b0, 1'b0);
      idle(1, 1);
      for (int i = 0; i < 12; i++) begin
         run_op(1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 63),
                1'($urandom_range(0, 1)), 1'b0);
      end
      idle(1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
